// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - instruction fetch unit: one outstanding request, 2-entry buffer, redirect flush
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc4,
  input  logic        instr_ready
);

  typedef enum logic [1:0] {FETCH, WAIT, DISCARD} state_e;

  state_e      state_q;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] out_pc_q;
  logic [31:0] data_q [0:1];
  logic [31:0] pc_q   [0:1];
  logic        rd_ptr_q, wr_ptr_q;
  logic [1:0]  cnt_q, cnt_d;

  logic req_fire, push, pop;

  assign imem_req_valid = !rst && (state_q == FETCH) && (cnt_q < 2'd2) && !redirect;
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A redirect flushes the buffer, so neither a same-cycle response nor a pop may touch it.
  assign push = (state_q == WAIT) && imem_rsp_valid && !redirect;
  assign pop  = instr_valid && instr_ready && !redirect;

  assign instr_valid = !rst && (cnt_q != 2'd0);
  assign instr       = instr_valid ? data_q[rd_ptr_q] : 32'h0;
  assign instr_pc    = instr_valid ? pc_q[rd_ptr_q]   : 32'h0;
  assign instr_pc4   = instr_pc + 32'd4;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect) begin
      fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
    end else if (req_fire) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
  end

  always_comb begin
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    if (redirect) begin
      cnt_d = 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FETCH;
      fetch_pc_q <= RESET_PC;
      out_pc_q   <= 32'h0;
      cnt_q      <= 2'd0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      cnt_q      <= cnt_d;
      if (req_fire) begin
        out_pc_q <= fetch_pc_q;
      end
      if (redirect) begin
        rd_ptr_q <= 1'b0;
        wr_ptr_q <= 1'b0;
      end else begin
        if (push) begin
          data_q[wr_ptr_q] <= imem_rsp_data;
          pc_q[wr_ptr_q]   <= out_pc_q;
          wr_ptr_q         <= ~wr_ptr_q;
        end
        if (pop) begin
          rd_ptr_q <= ~rd_ptr_q;
        end
      end
      // An outstanding request that survives a redirect must have its response dropped.
      if (redirect) begin
        state_q <= ((state_q != FETCH) && !imem_rsp_valid) ? DISCARD : FETCH;
      end else begin
        case (state_q)
          FETCH:         if (req_fire)       state_q <= WAIT;
          WAIT, DISCARD: if (imem_rsp_valid) state_q <= FETCH;
          default:                           state_q <= FETCH;
        endcase
      end
    end
  end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: fetch address loaded on reset.
REQ-002 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1: reset, synchronous and active-high.
REQ-004 SHALL have port imem_req_valid  output  1: fetch request valid.
REQ-005 SHALL have port imem_req_addr  output  32: word-aligned fetch address.
REQ-006 SHALL have port imem_req_ready  input  1: memory accepts the request.
REQ-007 SHALL have port imem_rsp_valid  input  1: response data valid, arriving one or more cycles after acceptance.
REQ-008 SHALL have port imem_rsp_data  input  32: fetched instruction word.
REQ-009 SHALL have port redirect  input  1: PC redirect for a taken branch or jump.
REQ-010 SHALL have port redirect_pc  input  32: redirect target.
REQ-011 SHALL have port instr_valid  output  1: instr, instr_pc and instr_pc4 are valid.
REQ-012 SHALL have port instr  output  32: instruction at the head of the buffer.
REQ-013 SHALL have port instr_pc  output  32: address of instr.
REQ-014 SHALL have port instr_pc4  output  32: instr_pc + 4, modulo 2^32.
REQ-015 SHALL have port instr_ready  input  1: the downstream datapath consumes the head entry.

Function
REQ-016 SHALL hold fetch_pc (32b) and a 2-entry FIFO of {instr, pc}, plus count (0..2).
REQ-017 SHALL implement FSM states FETCH, WAIT and DISCARD; at most one request outstanding.
REQ-018 SHALL drive imem_req_valid = (state==FETCH) & (count<2) & !redirect, and imem_req_addr = fetch_pc.
REQ-019 SHALL treat a request as accepted when imem_req_valid & imem_req_ready: fetch_pc <= fetch_pc+4 (wraps 32'hFFFF_FFFC -> 0); state <= WAIT; the accepted address is tagged as the outstanding pc.
REQ-020 SHALL keep imem_req_addr stable while imem_req_valid=1 and imem_req_ready=0, unless redirect is asserted.
REQ-021 In WAIT, on imem_rsp_valid, SHALL push {imem_rsp_data, outstanding pc} and set state <= FETCH; the next request may issue the following cycle, giving 2-cycle minimum issue-to-issue spacing.
REQ-022 SHALL drive instr_valid = (count>0), with instr/instr_pc taken from the head entry; a pop occurs on instr_valid & instr_ready.
REQ-023 A push and a pop in the same cycle SHALL leave count unchanged, with FIFO order preserved.
REQ-024 The FIFO SHALL never overflow; this is guaranteed by REQ-018, because a request is only issued when count<2 and only one request is outstanding.
REQ-025 redirect SHALL have priority over all other events:
  - FIFO flushed (count <= 0) and any same-cycle pop ignored;
  - fetch_pc <= {redirect_pc[31:2], 2'b00};
  - state <= DISCARD if in WAIT and no response arrives this cycle; otherwise state <= FETCH.
REQ-026 In DISCARD, SHALL drop the next imem_rsp_valid response without pushing it, then set state <= FETCH.
REQ-027 A redirect while in DISCARD SHALL update fetch_pc and remain in DISCARD.
REQ-028 imem_rsp_valid in FETCH (nothing outstanding) SHALL be ignored.
REQ-029 instr_valid SHALL be 0 in the cycle after a redirect.
REQ-030 The first redirected instruction SHALL appear no earlier than 2 cycles after redirect when the memory has zero wait states.

Reset
REQ-031 On rst=1 at a clock edge: fetch_pc <= RESET_PC; count <= 0; state <= FETCH; outstanding tag cleared.
REQ-032 While rst=1, outputs SHALL be: imem_req_valid=0, instr_valid=0, instr=0, instr_pc=0, instr_pc4=4.
REQ-033 rst SHALL override redirect and all handshakes; a response arriving after a reset taken mid-WAIT SHALL be ignored per REQ-028.

Verification
REQ-034 Stimulus: reset release, always-ready memory with 1-cycle response, instr_ready=1 -> required: addresses 0,4,8,... issued in order; instr_pc matches each fetched word; instr_pc4 = instr_pc+4.
REQ-035 Stimulus: instr_ready=0 for 10 cycles -> required: count saturates at 2, imem_req_valid=0; after release, entries drain in order 0 then 4.
REQ-036 Stimulus: redirect to 32'h0000_0103 while a request to 0x8 is outstanding -> required: the 0x8 response is dropped; next request addr = 0x100; first valid instr_pc = 0x100.
REQ-037 Stimulus: imem_req_ready held 0 for 3 cycles -> required: imem_req_addr stable at 0xC across those cycles; fetch_pc advances only on acceptance.
REQ-038 Stimulus: RESET_PC = 32'hFFFF_FFF8 -> required: fetch addresses FFFF_FFF8, FFFF_FFFC, 0000_0000; instr_pc4 for FFFF_FFFC = 0.
REQ-039 Stimulus: rst asserted in WAIT followed by a late imem_rsp_valid -> required: no push; instr_valid=0; next request addr = RESET_PC.
